// File: rtl/puf_measure_ctrl.sv
// Measurement sequencer for the ring-oscillator PUF array. It steps through RESP_W
// oscillator pairs and builds one response bit per pair from the two edge counts.
module puf_measure_ctrl #(
    parameter int N_OSC      = 16,
    parameter int SEL_W      = 4,
    parameter int CHAL_W     = 8,
    parameter int RESP_W     = 32,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4,
    parameter int DRAIN_CYC  = 3
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              start,
    input  logic              abort,
    input  logic [CHAL_W-1:0] challenge,
    input  logic [15:0]       window_len,
    input  logic [CNT_W-1:0]  cnt_a,
    input  logic [CNT_W-1:0]  cnt_b,
    output logic              osc_en,
    output logic [SEL_W-1:0]  osc_sel_a,
    output logic [SEL_W-1:0]  osc_sel_b,
    output logic              cnt_clr,
    output logic              busy,
    output logic              done,
    output logic              resp_valid,
    output logic [RESP_W-1:0] response,
    output logic [5:0]        tie_count
);

    localparam int IDX_W = (RESP_W > 1) ? $clog2(RESP_W) : 1;
    localparam logic [SEL_W-1:0] SEL_MASK = SEL_W'(N_OSC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SETTLE,
        S_MEASURE,
        S_DRAIN,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [15:0]       timer;
    logic [15:0]       win_len;
    logic [15:0]       win_m1;
    logic [IDX_W-1:0]  bit_idx;
    logic [SEL_W-1:0]  chal_base;
    logic              accept;
    logic              last_bit;

    generate
        if (CHAL_W >= SEL_W) begin : g_sel_slice
            assign chal_base = challenge[SEL_W-1:0] & SEL_MASK;
        end else begin : g_sel_extend
            assign chal_base = {{(SEL_W-CHAL_W){1'b0}}, challenge} & SEL_MASK;
        end
    endgenerate

    // A zero-length window still gets one counting cycle.
    assign win_m1   = (win_len == 16'd0) ? 16'd0 : win_len - 16'd1;
    assign accept   = (state == S_IDLE) && start && !abort;
    assign last_bit = (bit_idx == IDX_W'(RESP_W - 1));

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:    if (accept) next_state = S_CLEAR;
            S_CLEAR:   next_state = S_SETTLE;
            S_SETTLE:  if (timer == '0) next_state = S_MEASURE;
            S_MEASURE: if (timer == '0) next_state = S_DRAIN;
            S_DRAIN:   if (timer == '0) next_state = S_COMPARE;
            S_COMPARE: next_state = last_bit ? S_DONE : S_CLEAR;
            S_DONE:    next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            next_state = S_IDLE;
        end
    end

    // Strobes are registered from next_state so they line up exactly with the state.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            osc_en     <= 1'b0;
            cnt_clr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            resp_valid <= 1'b0;
            response   <= '0;
            tie_count  <= '0;
            osc_sel_a  <= '0;
            osc_sel_b  <= '0;
            timer      <= '0;
            win_len    <= '0;
            bit_idx    <= '0;
        end else begin
            osc_en  <= (next_state == S_MEASURE);
            cnt_clr <= (next_state == S_CLEAR);
            busy    <= (next_state != S_IDLE);
            done    <= (state == S_DONE) && !abort;

            if (state != next_state) begin
                case (next_state)
                    S_SETTLE:  timer <= 16'(SETTLE_CYC - 1);
                    S_MEASURE: timer <= win_m1;
                    S_DRAIN:   timer <= 16'(DRAIN_CYC - 1);
                    default:   timer <= '0;
                endcase
            end else if (timer != '0) begin
                timer <= timer - 16'd1;
            end

            if (accept) begin
                win_len    <= window_len;
                bit_idx    <= '0;
                response   <= '0;
                tie_count  <= '0;
                resp_valid <= 1'b0;
                osc_sel_a  <= chal_base;
                osc_sel_b  <= (chal_base + SEL_W'(1)) & SEL_MASK;
            end

            // Stepping both selects by two walks the pair sequence with natural wrap.
            if (state == S_COMPARE && !abort) begin
                response[bit_idx] <= (cnt_a > cnt_b);
                if (cnt_a == cnt_b) begin
                    tie_count <= tie_count + 6'd1;
                end
                if (!last_bit) begin
                    bit_idx   <= bit_idx + IDX_W'(1);
                    osc_sel_a <= (osc_sel_a + SEL_W'(2)) & SEL_MASK;
                    osc_sel_b <= (osc_sel_b + SEL_W'(2)) & SEL_MASK;
                end
            end

            if (state == S_DONE && !abort) begin
                resp_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_puf_measure_ctrl.sv
// Self-checking bench for puf_measure_ctrl: a per-oscillator count model feeds the DUT
// and a scoreboard of expected responses is compared at each done pulse.
module tb_puf_measure_ctrl;

    typedef struct {
        logic [31:0] resp;
        logic [5:0]  ties;
    } exp_t;

    logic        clk;
    logic        ARESETN;
    logic        start;
    logic        abort;
    logic [7:0]  challenge;
    logic [15:0] window_len;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic        osc_en;
    logic [3:0]  osc_sel_a;
    logic [3:0]  osc_sel_b;
    logic        cnt_clr;
    logic        busy;
    logic        done;
    logic        resp_valid;
    logic [31:0] response;
    logic [5:0]  tie_count;

    logic [15:0] osc_val [16];
    exp_t        exp_q[$];
    logic [3:0]  sela_q[$];
    logic [3:0]  selb_q[$];
    int          len_q[$];
    int          cyc = 0;
    int          cur_len = 0;
    int          done_cnt = 0;
    int          overlap_cnt = 0;
    bit          en_prev = 1'b0;
    int          checks = 0;
    int          failures = 0;

    puf_measure_ctrl dut (
        .ACLK       (clk),
        .ARESETN    (ARESETN),
        .start      (start),
        .abort      (abort),
        .challenge  (challenge),
        .window_len (window_len),
        .cnt_a      (cnt_a),
        .cnt_b      (cnt_b),
        .osc_en     (osc_en),
        .osc_sel_a  (osc_sel_a),
        .osc_sel_b  (osc_sel_b),
        .cnt_clr    (cnt_clr),
        .busy       (busy),
        .done       (done),
        .resp_valid (resp_valid),
        .response   (response),
        .tie_count  (tie_count)
    );

    assign cnt_a = osc_val[osc_sel_a];
    assign cnt_b = osc_val[osc_sel_b];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Observes osc_en pulses, the pair selected during each pulse, and done pulses.
    always @(negedge clk) begin
        if (osc_en === 1'b1 && cnt_clr === 1'b1) overlap_cnt = overlap_cnt + 1;
        if (osc_en === 1'b1) begin
            if (!en_prev) begin
                sela_q.push_back(osc_sel_a);
                selb_q.push_back(osc_sel_b);
                cur_len = 0;
            end
            cur_len = cur_len + 1;
        end else if (en_prev) begin
            len_q.push_back(cur_len);
        end
        en_prev = (osc_en === 1'b1);
        if (done === 1'b1) done_cnt = done_cnt + 1;
    end

    task automatic start_run(input logic [7:0] chal, input logic [15:0] win, output int acc);
        exp_t e;
        int   a;
        int   b;
        e.resp = '0;
        e.ties = '0;
        for (int i = 0; i < 32; i++) begin
            a = (int'(chal[3:0]) + 2 * i) % 16;
            b = (a + 1) % 16;
            if (osc_val[a] > osc_val[b]) e.resp[i] = 1'b1;
            else if (osc_val[a] == osc_val[b]) e.ties = e.ties + 6'd1;
        end
        exp_q.push_back(e);
        @(negedge clk);
        challenge  = chal;
        window_len = win;
        start      = 1'b1;
        @(posedge clk);
        #1;
        acc   = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit got, output int at_cyc);
        got    = 1'b0;
        at_cyc = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                got    = 1'b1;
                at_cyc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, output bit got);
        got = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (sela_q.size() >= target) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        ARESETN = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if ({osc_en, cnt_clr, busy, done, resp_valid} !== 5'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: got %b expected 00000", {osc_en, cnt_clr, busy, done, resp_valid});
        end
        checks++;
        if (response !== 32'h0 || tie_count !== 6'h0) begin
            failures++;
            $display("[TB] FAIL reset_result: got resp=%h ties=%0d expected resp=0 ties=0", response, tie_count);
        end
        checks++;
        if ({osc_sel_a, osc_sel_b} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL reset_sel: got %h expected 00", {osc_sel_a, osc_sel_b});
        end
        ARESETN = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (sela_q.size() !== 0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL idle_quiet: got pulses=%0d busy=%b expected pulses=0 busy=0", sela_q.size(), busy);
        end
    endtask

    task automatic check_result(input string name, input bit got, input int dcyc, input int acc, input int want_lat);
        exp_t e;
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL %s_timeout: got no done expected done", name);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
        checks++;
        if (response !== e.resp) begin
            failures++;
            $display("[TB] FAIL %s_response: got %h expected %h", name, response, e.resp);
        end
        checks++;
        if (tie_count !== e.ties) begin
            failures++;
            $display("[TB] FAIL %s_ties: got %0d expected %0d", name, tie_count, e.ties);
        end
        checks++;
        if (dcyc - acc !== want_lat) begin
            failures++;
            $display("[TB] FAIL %s_latency: got %0d expected %0d", name, dcyc - acc, want_lat);
        end
        checks++;
        if (resp_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s_status: got valid=%b busy=%b expected valid=1 busy=0", name, resp_valid, busy);
        end
    endtask

    task automatic test_nominal;
        int acc;
        int dcyc;
        int l0;
        int d0;
        int ov0;
        int bad;
        bit got;
        for (int x = 0; x < 16; x++) osc_val[x] = (x % 4 >= 2) ? 16'd100 : 16'd50;
        l0  = len_q.size();
        d0  = done_cnt;
        ov0 = overlap_cnt;
        start_run(8'h03, 16'd10, acc);
        wait_done(1000, got, dcyc);
        check_result("nominal", got, dcyc, acc, 609);
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || resp_valid !== 1'b1 || done_cnt !== d0 + 1) begin
            failures++;
            $display("[TB] FAIL nominal_done_pulse: got done=%b valid=%b pulses=%0d expected 0 1 %0d", done, resp_valid, done_cnt - d0, 1);
        end
        bad = 0;
        for (int k = l0; k < len_q.size(); k++) if (len_q[k] != 10) bad++;
        checks++;
        if (len_q.size() - l0 !== 32 || bad !== 0) begin
            failures++;
            $display("[TB] FAIL nominal_en_pulses: got count=%0d badlen=%0d expected 32 0", len_q.size() - l0, bad);
        end
        checks++;
        if (overlap_cnt !== ov0) begin
            failures++;
            $display("[TB] FAIL clr_en_overlap: got %0d expected 0", overlap_cnt - ov0);
        end
    endtask

    task automatic test_wrap;
        int acc;
        int dcyc;
        int p0;
        int bad;
        bit got;
        for (int x = 0; x < 16; x++) osc_val[x] = 16'($urandom_range(0, 3));
        p0 = sela_q.size();
        start_run(8'h0F, 16'd2, acc);
        wait_done(1000, got, dcyc);
        check_result("wrap", got, dcyc, acc, 353);
        checks++;
        if ({sela_q[p0], selb_q[p0]} !== 8'hF0) begin
            failures++;
            $display("[TB] FAIL wrap_pair0: got %h expected f0", {sela_q[p0], selb_q[p0]});
        end
        checks++;
        if ({sela_q[p0+1], selb_q[p0+1]} !== 8'h12) begin
            failures++;
            $display("[TB] FAIL wrap_pair1: got %h expected 12", {sela_q[p0+1], selb_q[p0+1]});
        end
        checks++;
        if ({sela_q[p0+8], selb_q[p0+8]} !== 8'hF0) begin
            failures++;
            $display("[TB] FAIL wrap_pair8: got %h expected f0", {sela_q[p0+8], selb_q[p0+8]});
        end
        bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (int'(sela_q[p0+k]) != (15 + 2 * k) % 16 || int'(selb_q[p0+k]) != (16 + 2 * k) % 16) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL wrap_sequence: got %0d wrong pairs expected 0", bad);
        end
    endtask

    task automatic test_ties_window0;
        int acc;
        int dcyc;
        int l0;
        int bad;
        bit got;
        for (int x = 0; x < 16; x++) osc_val[x] = 16'd7;
        l0 = len_q.size();
        start_run(8'h00, 16'd0, acc);
        wait_done(1000, got, dcyc);
        check_result("ties", got, dcyc, acc, 321);
        @(negedge clk);
        bad = 0;
        for (int k = l0; k < len_q.size(); k++) if (len_q[k] != 1) bad++;
        checks++;
        if (len_q.size() - l0 !== 32 || bad !== 0) begin
            failures++;
            $display("[TB] FAIL window0_pulses: got count=%0d badlen=%0d expected 32 0", len_q.size() - l0, bad);
        end
    endtask

    task automatic test_abort_restart;
        int acc;
        int dcyc;
        int p0;
        int d0;
        bit got;
        for (int x = 0; x < 16; x++) osc_val[x] = 16'(x * 3 + 1);
        p0 = sela_q.size();
        d0 = done_cnt;
        start_run(8'h21, 16'd10, acc);
        wait_pulses(p0 + 6, 400, got);
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL abort_reach_bit5: got no pulse expected pulse 6");
        end
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || osc_en !== 1'b0 || done !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_status: got busy=%b en=%b done=%b valid=%b expected 0000", busy, osc_en, done, resp_valid);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        for (int x = 0; x < 16; x++) osc_val[x] = 16'(200 - x * 5);
        start_run(8'h0A, 16'd3, acc);
        wait_done(1000, got, dcyc);
        check_result("restart", got, dcyc, acc, 385);
        @(negedge clk);
        checks++;
        if (done_cnt !== d0 + 1) begin
            failures++;
            $display("[TB] FAIL abort_no_done: got %0d done pulses expected 1", done_cnt - d0);
        end
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cnt_clr !== 1'b0 || resp_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL abort_beats_start: got busy=%b clr=%b valid=%b expected 0 0 1", busy, cnt_clr, resp_valid);
        end
    endtask

    task automatic test_ignored_start_and_reset;
        int acc;
        int dcyc;
        int p0;
        int l0;
        int bad;
        bit got;
        for (int x = 0; x < 16; x++) osc_val[x] = 16'($urandom_range(10, 20));
        p0 = sela_q.size();
        start_run(8'h06, 16'd5, acc);
        wait_pulses(p0 + 3, 400, got);
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL ignore_reach_bit2: got no pulse expected pulse 3");
        end
        challenge  = 8'hAA;
        window_len = 16'd1;
        start      = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_done(1000, got, dcyc);
        check_result("ignored_start", got, dcyc, acc, 449);
        bad = 0;
        for (int k = 0; k < 32; k++) if (int'(sela_q[p0+k]) != (6 + 2 * k) % 16) bad++;
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("[TB] FAIL ignored_start_sel: got %0d wrong pairs expected 0", bad);
        end
        l0 = len_q.size();
        start_run(8'h09, 16'd4, acc);
        got = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (len_q.size() > l0) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL reset_reach_drain: got no pulse end expected pulse end");
        end
        ARESETN = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if ({osc_en, cnt_clr, busy, done, resp_valid} !== 5'b0 || response !== 32'h0 ||
            tie_count !== 6'h0 || {osc_sel_a, osc_sel_b} !== 8'h00) begin
            failures++;
            $display("[TB] FAIL midrun_reset: got flags=%b resp=%h ties=%0d sel=%h expected all zero",
                     {osc_en, cnt_clr, busy, done, resp_valid}, response, tie_count, {osc_sel_a, osc_sel_b});
        end
        ARESETN = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (3) @(negedge clk);
    endtask

    initial begin
        ARESETN    = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        challenge  = 8'h00;
        window_len = 16'd0;
        for (int x = 0; x < 16; x++) osc_val[x] = 16'd0;
        test_reset;
        test_nominal;
        test_wrap;
        test_ties_window0;
        test_abort_restart;
        test_ignored_start_and_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/puf_measure_ctrl.md
Name: puf_measure_ctrl

Overview:
- Sequencer for the inverter-chain PUF oscillator array; sits between the AXI4-Lite register slave and the ring-oscillator/edge-counter datapath.
- On start, it builds a RESP_W-bit response, one bit per oscillator pair.
- Per bit: select the pair from the challenge, clear the counters, settle, enable for a counting window, drain the synchronisers, compare the two counts.
- Reports busy/done, the response word and a tie count back to the register file.

Parameters:
N_OSC, 16, number of ring oscillators in the array (power of 2, ≥2)
SEL_W, 4, log2(N_OSC), width of the oscillator select
CHAL_W, 8, challenge width
RESP_W, 32, response bits per measurement
CNT_W, 16, edge-counter width
SETTLE_CYC, 4, cycles with selection stable before enable (≥1)
DRAIN_CYC, 3, cycles after disable before compare, covers counter CDC latency (≥1)

Ports:
ACLK  in  1  clock
ARESETN  in  1  synchronous active-low reset
start  in  1  begin measurement; accepted only in IDLE
abort  in  1  cancel measurement in progress
challenge  in  CHAL_W  challenge, latched on start accept
window_len  in  16  counting window in ACLK cycles, latched on start accept; 0 is treated as 1
cnt_a  in  CNT_W  edge count of oscillator osc_sel_a (ACLK-synchronised)
cnt_b  in  CNT_W  edge count of oscillator osc_sel_b
osc_en  out  1  enable the selected oscillators
osc_sel_a  out  SEL_W  first oscillator of the current pair
osc_sel_b  out  SEL_W  second oscillator of the current pair
cnt_clr  out  1  synchronous clear of both counters
busy  out  1  high from start accept until done/abort
done  out  1  one-cycle pulse when the response is complete
resp_valid  out  1  response holds a complete result
response  out  RESP_W  result bits; bit i comes from pair i
tie_count  out  6  number of bits whose counts tied

Behaviour:
- Reset (ARESETN=0 at a rising ACLK edge):
  - State goes to IDLE.
  - All outputs go to 0, including response, tie_count, osc_sel_a/b and resp_valid.
  - Reset mid-measurement drops osc_en on the following edge.
- State machine: IDLE→CLEAR→SETTLE→MEASURE→DRAIN→COMPARE→(CLEAR | DONE)→IDLE.
- IDLE, start=1:
  - Latch challenge and window_len; set bit index i=0.
  - Clear response and tie_count; set resp_valid=0 and busy=1.
  - Go to CLEAR.
- Pair selection:
  - sel_base = challenge[SEL_W-1:0] (zero-extended if CHAL_W<SEL_W).
  - osc_sel_a = (sel_base + 2i) mod N_OSC; osc_sel_b = (sel_base + 2i + 1) mod N_OSC. Wrap-around by truncation.
  - Both are registered on entry to CLEAR and held stable through COMPARE.
- CLEAR: 1 cycle, cnt_clr=1, osc_en=0.
- SETTLE: SETTLE_CYC cycles, osc_en=0.
- MEASURE: exactly max(window_len,1) cycles with osc_en=1.
- DRAIN: DRAIN_CYC cycles, osc_en=0.
- COMPARE: 1 cycle.
  - response[i] = (cnt_a > cnt_b), unsigned comparison.
  - If cnt_a == cnt_b: bit = 0 and tie_count += 1.
  - If i = RESP_W-1, go to DONE; otherwise i += 1 and go to CLEAR.
- DONE: 1 cycle.
  - done=1, resp_valid=1, busy=0 on the same edge; then IDLE.
  - response and resp_valid hold until the next accepted start or reset.
- Cycles per bit: 2 + SETTLE_CYC + W + DRAIN_CYC, where W = max(window_len,1).
  - done is asserted RESP_W × that count + 1 cycles after the start-accept edge.
- start while busy: ignored; latched challenge and window are unaffected.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; osc_en=0, busy=0, no done pulse.
  - resp_valid stays 0; the partial response is retained but invalid.
  - abort and start together in IDLE: abort wins, nothing starts.
- osc_en is a registered output and is never high outside MEASURE.
- cnt_clr is never high in the same cycle as osc_en.

Test Plan:
- Reset/idle: hold ARESETN=0 for 5 cycles, then release with no start → all outputs 0 and osc_en never rises.
- Nominal run: challenge=0x03, window_len=10, cnt_a=100/cnt_b=50 on even i and cnt_a=50/cnt_b=100 on odd i → response=0x55555555, tie_count=0, done exactly 609 cycles after start accept, one osc_en pulse of 10 cycles per bit.
- Wrap-around: challenge=0x0F → pair 0 = (15,0), pair 1 = (1,2), pair 8 = (15,0); check osc_sel values at each COMPARE.
- Ties and window 0: window_len=0, cnt_a=cnt_b=7 for all bits → each MEASURE lasts 1 cycle, response=0, tie_count=32.
- Abort/restart: abort during MEASURE of bit 5 → busy=0 and osc_en=0 one cycle later, no done, resp_valid=0; an immediate restart completes normally.
- Ignored start and mid-run reset: pulse start with a new challenge during bit 2 → no effect on the run. ARESETN=0 during DRAIN → all outputs 0 on the next edge.
